// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, next_state;

    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q, m;
    logic [CNT_W-1:0]   cnt;
    logic               div_r, neg_q, neg_r, dz;
    logic               idle_like, accept, is_signed, is_div, zero_div;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    assign idle_like   = state == IDLE || state == DONE;
    assign accept      = idle_like && start;
    assign is_signed   = ~op[0];
    assign is_div      = op[1];
    assign zero_div    = is_div && b == '0;
    assign a_abs       = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs       = (is_signed && b[WIDTH-1]) ? -b : b;
    // acc holds the running upper half (product) or partial remainder (divide)
    assign add_sum     = {1'b0, acc[WIDTH-1:0]} + {1'b0, q[0] ? m : '0};
    assign shifted     = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff        = shifted - {1'b0, m};
    assign prod        = {acc[WIDTH-1:0], q};
    assign busy        = state == RUN || state == FIX;
    assign done        = state == DONE;
    assign div_by_zero = done && dz;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = accept ? (zero_div ? DONE : RUN) : IDLE;
            RUN:        next_state = cnt == CNT_W'(WIDTH - 1) ? FIX : RUN;
            FIX:        next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= next_state;
            if (idle_like && hi_we) hi <= wdata;
            if (idle_like && lo_we) lo <= wdata;
            if (accept) begin
                div_r <= is_div;
                m     <= is_div ? b_abs : a_abs;
                q     <= is_div ? a_abs : b_abs;
                acc   <= '0;
                cnt   <= '0;
                neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= is_signed && a[WIDTH-1];
                dz    <= zero_div;
            end
            if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= div_r ? (diff[WIDTH] ? shifted : diff) : {1'b0, add_sum[WIDTH:1]};
                q   <= div_r ? {q[WIDTH-2:0], ~diff[WIDTH]} : {add_sum[0], q[WIDTH-1:1]};
            end
            if (state == FIX) begin
                if (div_r) begin
                    lo <= neg_q ? -q : q;
                    hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                end else begin
                    {hi, lo} <= neg_q ? -prod : prod;
                end
            end
        end
    end
endmodule
